imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Boot-time controller that fills the instruction memory from a byte-stream link (UART/JTAG bridge) with a valid/ready handshake.
- Holds the core in reset while loading, checks a length header and an XOR checksum, then releases the core so it starts executing at pc 0.
- Sits in the toplevel between the host link, the instruction-memory write port and the core's reset input.

Parameters:
- p_ADDR_LEN, 10, instruction-memory address width; capacity is 2**p_ADDR_LEN words.
- p_TIMEOUT, 1000, idle cycles allowed between bytes once a load has started.

Ports:
- i_clk  in  1  global clock
- i_rst_n  in  1  asynchronous active-low reset
- i_restart  in  1  one-cycle pulse; starts a new load from RUN or ERROR
- i_byte  in  8  incoming byte
- i_valid  in  1  byte available
- o_ready  out  1  loader accepts a byte this cycle
- o_imem_wr_en  out  1  instruction-memory write strobe
- o_imem_addr  out  p_ADDR_LEN  write word address
- o_imem_wr_data  out  16  write data
- o_core_rst  out  1  active-high reset to the core
- o_done  out  1  load succeeded; core running
- o_err  out  1  load failed
- o_err_code  out  2  01 length, 10 checksum, 11 timeout, 00 none

Behaviour:
- Transfer occurs on a clock edge when i_valid && o_ready. o_ready is a pure function of state: 1 in LEN_LO, LEN_HI, DATA_LO, DATA_HI and CHK; 0 otherwise.
- Reset values: state IDLE, o_ready 0, o_imem_wr_en 0, o_imem_addr 0, o_imem_wr_data 0, o_core_rst 1, o_done 0, o_err 0, o_err_code 00. Word counter, checksum register and timeout counter are 0.
- Protocol: length N (16 bit, low byte first), then N words (each low byte first), then one checksum byte. The checksum is the XOR of all data bytes; length bytes are excluded.
- State machine:
  - IDLE -> LEN_LO unconditionally on the first clock after reset release.
  - LEN_LO --byte--> LEN_HI; latch N[7:0].
  - LEN_HI --byte--> latch N[15:8], then:
    - N > 2**p_ADDR_LEN -> ERROR (code 01).
    - N == 0 -> CHK.
    - otherwise -> DATA_LO.
  - DATA_LO --byte--> DATA_HI; latch the low byte.
  - DATA_HI --byte--> write the word. Next state is CHK if this was word N-1, else DATA_LO.
  - CHK --byte--> if byte == running XOR, go to RUN; otherwise ERROR (code 10).
  - RUN and ERROR: on i_restart, go to LEN_LO. Restart clears counters, checksum, o_done, o_err and o_err_code, and sets o_core_rst 1 in the same edge.
  - i_restart is ignored in all other states.
- Write timing: o_imem_wr_en is a registered one-cycle pulse in the cycle after the DATA_HI byte is accepted. o_imem_wr_data = {hi, lo}; o_imem_addr = word index (0..N-1). o_imem_addr and o_imem_wr_data hold their values between writes.
- Checksum: XOR updated on every accepted DATA_LO/DATA_HI byte.
- Core release: o_core_rst falls and o_done rises on the edge that accepts a correct checksum byte, and both hold until restart. In ERROR, o_core_rst stays 1 and o_err is 1.
- Timeout:
  - The counter runs in LEN_HI, DATA_LO, DATA_HI and CHK, and clears on every accepted byte.
  - When it reaches p_TIMEOUT, the next state is ERROR (code 11).
  - LEN_LO never times out (host may be absent indefinitely).
- A byte accepted in the same cycle the counter reaches p_TIMEOUT wins; no error is raised.
- i_valid while o_ready is 0 is ignored; no byte is consumed.
- An async reset mid-load aborts immediately and restores reset values. No further writes occur; partially written memory is left as is.
- An N exactly equal to 2**p_ADDR_LEN is legal; the last write goes to address 2**p_ADDR_LEN - 1.

Test Plan:
- Nominal load:
  - Stimulus: bytes 02 00 34 12 CD AB 40, one per cycle.
  - Writes: 0x1234 to addr 0, then 0xABCD to addr 1, each as a single pulse.
  - After 0x40 is accepted: o_core_rst 0, o_done 1, o_err 0.
- Bad checksum: same stream with final byte 41 -> o_err 1, o_err_code 10, o_core_rst stays 1, o_ready 0.
- Length overflow (p_ADDR_LEN=10): bytes 01 04 (N=1025) -> ERROR code 01 after the 2nd byte, no write pulses. Bytes 00 04 (N=1024) are accepted.
- Zero length and backpressure:
  - Bytes 00 00 00 -> RUN with no writes.
  - i_valid held with random gaps shorter than p_TIMEOUT -> same result as back-to-back delivery.
- Timeout (p_TIMEOUT=1000):
  - Send 02 00 34, then stall -> ERROR code 11 exactly 1000 cycles after the 34 byte.
  - Stall in LEN_LO for 5000 cycles -> no error.
- Restart and mid-load reset:
  - From ERROR, pulse i_restart and send the nominal stream -> RUN, flags cleared.
  - Assert i_rst_n low after the 4th byte -> all outputs at reset values; state is LEN_LO two edges after release.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Boot-time loader that fills the instruction memory from a byte stream
// (valid/ready handshake) while holding the core in reset. The stream is
// a 16-bit word count N (low byte first), then N 16-bit words (low byte
// first), then one checksum byte equal to the XOR of every data byte.
// A correct checksum releases the core. A bad length, a bad checksum or
// an inter-byte timeout parks the loader in ERROR until i_restart.
//
// Ports:
//   i_clk           global clock
//   i_rst_n         asynchronous active-low reset
//   i_restart       one-cycle pulse, starts a new load from RUN or ERROR
//   i_byte          incoming byte
//   i_valid         incoming byte is available
//   o_ready         loader accepts a byte this cycle
//   o_imem_wr_en    instruction-memory write strobe (one-cycle pulse)
//   o_imem_addr     write word address
//   o_imem_wr_data  write data {hi, lo}
//   o_core_rst      active-high reset to the core
//   o_done          load succeeded and the core is running
//   o_err           load failed
//   o_err_code      01 length, 10 checksum, 11 timeout, 00 none
module imem_boot_loader #(
    parameter int p_ADDR_LEN = 10,
    parameter int p_TIMEOUT  = 1000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_restart,
    input  logic [7:0]            i_byte,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_imem_wr_en,
    output logic [p_ADDR_LEN-1:0] o_imem_addr,
    output logic [15:0]           o_imem_wr_data,
    output logic                  o_core_rst,
    output logic                  o_done,
    output logic                  o_err,
    output logic [1:0]            o_err_code
);

    localparam int                c_TMO_W    = $clog2(p_TIMEOUT + 1);
    // Largest legal word count; compared on 17 bits so 2**16 cannot wrap.
    localparam logic [16:0]       c_CAPACITY = 17'd1 << p_ADDR_LEN;
    // The error is raised on the edge where the counter would reach p_TIMEOUT.
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(p_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_LO  = 3'd1,
        ST_LEN_HI  = 3'd2,
        ST_DATA_LO = 3'd3,
        ST_DATA_HI = 3'd4,
        ST_CHK     = 3'd5,
        ST_RUN     = 3'd6,
        ST_ERROR   = 3'd7
    } state_t;

    // Running checksum: XOR fold of one more data byte.
    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    state_t               state_r, state_next_s;
    logic [15:0]          len_r, len_nxt_s;
    logic [7:0]           lo_byte_r, lo_byte_nxt_s;
    logic [15:0]          word_cnt_r, word_cnt_nxt_s;
    logic [7:0]           chk_r, chk_nxt_s;
    logic [c_TMO_W-1:0]   tmo_cnt_r, tmo_cnt_nxt_s;
    logic                 ready_r, ready_nxt_s;
    logic                 wr_en_r, wr_en_nxt_s;
    logic [p_ADDR_LEN-1:0] addr_r, addr_nxt_s;
    logic [15:0]          wr_data_r, wr_data_nxt_s;
    logic                 core_rst_r, core_rst_nxt_s;
    logic                 done_r, done_nxt_s;
    logic                 err_r, err_nxt_s;
    logic [1:0]           err_code_r, err_code_nxt_s;

    logic                 accept_s;
    logic                 tmo_run_s;
    logic                 tmo_hit_s;
    logic [15:0]          len_full_s;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, datapath and output decode.
    always_comb begin
        accept_s       = i_valid && ready_r;
        tmo_run_s      = (state_r == ST_LEN_HI) || (state_r == ST_DATA_LO) ||
                         (state_r == ST_DATA_HI) || (state_r == ST_CHK);
        tmo_hit_s      = tmo_run_s && (tmo_cnt_r == c_TMO_LAST);
        len_full_s     = {i_byte, len_r[7:0]};

        state_next_s   = state_r;
        len_nxt_s      = len_r;
        lo_byte_nxt_s  = lo_byte_r;
        word_cnt_nxt_s = word_cnt_r;
        chk_nxt_s      = chk_r;
        tmo_cnt_nxt_s  = tmo_cnt_r;
        wr_en_nxt_s    = 1'b0;
        addr_nxt_s     = addr_r;
        wr_data_nxt_s  = wr_data_r;
        core_rst_nxt_s = core_rst_r;
        done_nxt_s     = done_r;
        err_nxt_s      = err_r;
        err_code_nxt_s = err_code_r;

        // Inter-byte watchdog: counts idle cycles, any accepted byte clears it.
        if (tmo_run_s) begin
            if (accept_s) begin
                tmo_cnt_nxt_s = {c_TMO_W{1'b0}};
            end else begin
                tmo_cnt_nxt_s = tmo_cnt_r + c_TMO_W'(1);
            end
        end else begin
            tmo_cnt_nxt_s = tmo_cnt_r;
        end

        case (state_r)
            ST_IDLE: begin
                state_next_s = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (accept_s) begin
                    len_nxt_s    = {len_r[15:8], i_byte};
                    state_next_s = ST_LEN_HI;
                end else begin
                    state_next_s = ST_LEN_LO;
                end
            end
            ST_LEN_HI: begin
                if (accept_s) begin
                    len_nxt_s = len_full_s;
                    if ({1'b0, len_full_s} > c_CAPACITY) begin
                        state_next_s   = ST_ERROR;
                        err_nxt_s      = 1'b1;
                        err_code_nxt_s = 2'b01;
                    end else if (len_full_s == 16'd0) begin
                        state_next_s = ST_CHK;
                    end else begin
                        state_next_s = ST_DATA_LO;
                    end
                end else if (tmo_hit_s) begin
                    state_next_s   = ST_ERROR;
                    err_nxt_s      = 1'b1;
                    err_code_nxt_s = 2'b11;
                end else begin
                    state_next_s = ST_LEN_HI;
                end
            end
            ST_DATA_LO: begin
                if (accept_s) begin
                    lo_byte_nxt_s = i_byte;
                    chk_nxt_s     = chk_update(chk_r, i_byte);
                    state_next_s  = ST_DATA_HI;
                end else if (tmo_hit_s) begin
                    state_next_s   = ST_ERROR;
                    err_nxt_s      = 1'b1;
                    err_code_nxt_s = 2'b11;
                end else begin
                    state_next_s = ST_DATA_LO;
                end
            end
            ST_DATA_HI: begin
                if (accept_s) begin
                    wr_en_nxt_s    = 1'b1;
                    addr_nxt_s     = word_cnt_r[p_ADDR_LEN-1:0];
                    wr_data_nxt_s  = {i_byte, lo_byte_r};
                    chk_nxt_s      = chk_update(chk_r, i_byte);
                    word_cnt_nxt_s = word_cnt_r + 16'd1;
                    // len_r is non-zero here, so len_r - 1 cannot underflow.
                    if (word_cnt_r == (len_r - 16'd1)) begin
                        state_next_s = ST_CHK;
                    end else begin
                        state_next_s = ST_DATA_LO;
                    end
                end else if (tmo_hit_s) begin
                    state_next_s   = ST_ERROR;
                    err_nxt_s      = 1'b1;
                    err_code_nxt_s = 2'b11;
                end else begin
                    state_next_s = ST_DATA_HI;
                end
            end
            ST_CHK: begin
                if (accept_s) begin
                    if (i_byte == chk_r) begin
                        state_next_s   = ST_RUN;
                        core_rst_nxt_s = 1'b0;
                        done_nxt_s     = 1'b1;
                    end else begin
                        state_next_s   = ST_ERROR;
                        err_nxt_s      = 1'b1;
                        err_code_nxt_s = 2'b10;
                    end
                end else if (tmo_hit_s) begin
                    state_next_s   = ST_ERROR;
                    err_nxt_s      = 1'b1;
                    err_code_nxt_s = 2'b11;
                end else begin
                    state_next_s = ST_CHK;
                end
            end
            ST_RUN, ST_ERROR: begin
                if (i_restart) begin
                    state_next_s   = ST_LEN_LO;
                    len_nxt_s      = 16'd0;
                    word_cnt_nxt_s = 16'd0;
                    chk_nxt_s      = 8'd0;
                    tmo_cnt_nxt_s  = {c_TMO_W{1'b0}};
                    core_rst_nxt_s = 1'b1;
                    done_nxt_s     = 1'b0;
                    err_nxt_s      = 1'b0;
                    err_code_nxt_s = 2'b00;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        // Ready is registered from the next state so it is a clean function of state_r.
        ready_nxt_s = (state_next_s == ST_LEN_LO) || (state_next_s == ST_LEN_HI) ||
                      (state_next_s == ST_DATA_LO) || (state_next_s == ST_DATA_HI) ||
                      (state_next_s == ST_CHK);
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            len_r      <= 16'd0;
            lo_byte_r  <= 8'd0;
            word_cnt_r <= 16'd0;
            chk_r      <= 8'd0;
            tmo_cnt_r  <= {c_TMO_W{1'b0}};
            ready_r    <= 1'b0;
            wr_en_r    <= 1'b0;
            addr_r     <= {p_ADDR_LEN{1'b0}};
            wr_data_r  <= 16'd0;
            core_rst_r <= 1'b1;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= 2'b00;
        end else begin
            len_r      <= len_nxt_s;
            lo_byte_r  <= lo_byte_nxt_s;
            word_cnt_r <= word_cnt_nxt_s;
            chk_r      <= chk_nxt_s;
            tmo_cnt_r  <= tmo_cnt_nxt_s;
            ready_r    <= ready_nxt_s;
            wr_en_r    <= wr_en_nxt_s;
            addr_r     <= addr_nxt_s;
            wr_data_r  <= wr_data_nxt_s;
            core_rst_r <= core_rst_nxt_s;
            done_r     <= done_nxt_s;
            err_r      <= err_nxt_s;
            err_code_r <= err_code_nxt_s;
        end
    end

    assign o_ready        = ready_r;
    assign o_imem_wr_en   = wr_en_r;
    assign o_imem_addr    = addr_r;
    assign o_imem_wr_data = wr_data_r;
    assign o_core_rst     = core_rst_r;
    assign o_done         = done_r;
    assign o_err          = err_r;
    assign o_err_code     = err_code_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader
// Directed bench for imem_boot_loader. Expected memory writes are pushed
// to a queue as the data bytes are driven and popped when the write strobe
// is seen; status flags are compared at fixed points of the sequence.
module tb_imem_boot_loader;

    localparam int c_ADDR_LEN = 10;
    localparam int c_TIMEOUT  = 1000;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  restart;
    logic [7:0]            byte_in;
    logic                  valid;
    logic                  ready;
    logic                  wr_en;
    logic [c_ADDR_LEN-1:0] addr;
    logic [15:0]           wr_data;
    logic                  core_rst;
    logic                  done;
    logic                  err;
    logic [1:0]            err_code;

    typedef struct packed {
        logic [c_ADDR_LEN-1:0] addr;
        logic [15:0]           data;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    imem_boot_loader #(.p_ADDR_LEN(c_ADDR_LEN), .p_TIMEOUT(c_TIMEOUT)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_restart      (restart),
        .i_byte         (byte_in),
        .i_valid        (valid),
        .o_ready        (ready),
        .o_imem_wr_en   (wr_en),
        .o_imem_addr    (addr),
        .o_imem_wr_data (wr_data),
        .o_core_rst     (core_rst),
        .o_done         (done),
        .o_err          (err),
        .o_err_code     (err_code)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard the write port at the falling edge, return 1 time unit after the rising edge.
    task automatic tick();
        wr_t w;
        @(negedge clk);
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_spurious", 32'(wr_en), 32'd0);
            end else begin
                w = exp_q.pop_front();
                check("wr_addr", 32'(addr), 32'(w.addr));
                check("wr_data", 32'(wr_data), 32'(w.data));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int max_gap);
        int k;
        if (max_gap > 0) begin
            repeat ($urandom_range(0, max_gap)) tick();
        end
        valid   = 1'b1;
        byte_in = b;
        k = 0;
        while (ready !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        if (k >= 50) check("ready_wait", 32'(ready), 32'd1);
        tick();
        valid = 1'b0;
    endtask

    task automatic send_word(input logic [c_ADDR_LEN-1:0] a, input logic [15:0] d, input int max_gap);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
        send(d[7:0], max_gap);
        send(d[15:8], max_gap);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("rs_done", 32'(done), 32'd0);
        check("rs_err", 32'(err), 32'd0);
        check("rs_code", 32'(err_code), 32'd0);
        check("rs_core_rst", 32'(core_rst), 32'd1);
        check("rs_ready", 32'(ready), 32'd1);
    endtask

    task automatic send_nominal(input logic [7:0] chk_byte, input int max_gap);
        send(8'h02, max_gap);
        send(8'h00, max_gap);
        send_word(10'd0, 16'h1234, max_gap);
        send_word(10'd1, 16'hABCD, max_gap);
        send(chk_byte, max_gap);
    endtask

    task automatic check_queue_drained(input string tag);
        tick();
        tick();
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [15:0] d;
        logic [7:0]  chk;

        rst_n   = 1'b0;
        restart = 1'b0;
        valid   = 1'b0;
        byte_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;

        // Reset values.
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_data", 32'(wr_data), 32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        rst_n = 1'b1;
        check("idle_ready", 32'(ready), 32'd0);
        tick();
        check("lenlo_ready", 32'(ready), 32'd1);

        // Nominal load.
        send_nominal(8'h40, 0);
        check("nom_core_rst", 32'(core_rst), 32'd0);
        check("nom_done", 32'(done), 32'd1);
        check("nom_err", 32'(err), 32'd0);
        check("nom_ready", 32'(ready), 32'd0);
        check_queue_drained("nom_writes");
        check("nom_addr_hold", 32'(addr), 32'd1);
        check("nom_data_hold", 32'(wr_data), 32'hABCD);

        // Valid while not ready consumes nothing and writes nothing.
        valid   = 1'b1;
        byte_in = 8'h55;
        repeat (5) tick();
        valid = 1'b0;
        check("ign_done", 32'(done), 32'd1);
        check("ign_ready", 32'(ready), 32'd0);

        // Bad checksum.
        do_restart();
        send_nominal(8'h41, 0);
        check("bad_err", 32'(err), 32'd1);
        check("bad_code", 32'(err_code), 32'd2);
        check("bad_core_rst", 32'(core_rst), 32'd1);
        check("bad_ready", 32'(ready), 32'd0);
        check("bad_done", 32'(done), 32'd0);
        check_queue_drained("bad_writes");

        // Length overflow: N = 1025.
        do_restart();
        send(8'h01, 0);
        send(8'h04, 0);
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_code", 32'(err_code), 32'd1);
        check("ovf_ready", 32'(ready), 32'd0);
        repeat (4) tick();

        // Full capacity: N = 1024, last word lands at address 1023.
        do_restart();
        send(8'h00, 0);
        send(8'h04, 0);
        check("full_hdr_err", 32'(err), 32'd0);
        check("full_hdr_ready", 32'(ready), 32'd1);
        chk = 8'h00;
        for (int i = 0; i < 1024; i++) begin
            d = 16'(i * 40503);
            chk = chk ^ d[7:0] ^ d[15:8];
            send_word(10'(i), d, 0);
        end
        send(chk, 0);
        check("full_done", 32'(done), 32'd1);
        check("full_err", 32'(err), 32'd0);
        check_queue_drained("full_writes");
        check("full_last_addr", 32'(addr), 32'd1023);

        // Zero length.
        do_restart();
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_core_rst", 32'(core_rst), 32'd0);
        check_queue_drained("zero_writes");

        // Random gaps between bytes.
        do_restart();
        send_nominal(8'h40, 7);
        check("gap_done", 32'(done), 32'd1);
        check("gap_err", 32'(err), 32'd0);
        check_queue_drained("gap_writes");

        // Timeout exactly 1000 cycles after the last accepted byte.
        do_restart();
        send(8'h02, 0);
        send(8'h00, 0);
        send(8'h34, 0);
        repeat (c_TIMEOUT - 1) tick();
        check("tmo_early_err", 32'(err), 32'd0);
        check("tmo_early_ready", 32'(ready), 32'd1);
        tick();
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_code", 32'(err_code), 32'd3);
        check("tmo_ready", 32'(ready), 32'd0);
        check("tmo_core_rst", 32'(core_rst), 32'd1);

        // A byte arriving on the timeout cycle wins.
        do_restart();
        send(8'h02, 0);
        send(8'h00, 0);
        send(8'h34, 0);
        repeat (c_TIMEOUT - 1) tick();
        send(8'h12, 0);
        check("win_err", 32'(err), 32'd0);
        check("win_ready", 32'(ready), 32'd1);
        check("win_wr_en", 32'(wr_en), 32'd1);
        check("win_wr_data", 32'(wr_data), 32'h1234);

        // Asynchronous reset after the 4th byte kills the pending write.
        rst_n = 1'b0;
        #2;
        check("mid_wr_en", 32'(wr_en), 32'd0);
        check("mid_addr", 32'(addr), 32'd0);
        check("mid_data", 32'(wr_data), 32'd0);
        check("mid_ready", 32'(ready), 32'd0);
        check("mid_core_rst", 32'(core_rst), 32'd1);
        check("mid_done", 32'(done), 32'd0);
        check("mid_err", 32'(err), 32'd0);
        check("mid_code", 32'(err_code), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        check("mid_rel_ready", 32'(ready), 32'd0);
        tick();
        tick();
        check("mid_lenlo_ready", 32'(ready), 32'd1);

        // Idle host in LEN_LO never times out.
        repeat (5000) tick();
        check("stall_err", 32'(err), 32'd0);
        check("stall_ready", 32'(ready), 32'd1);
        check("stall_core_rst", 32'(core_rst), 32'd1);

        // Loader still works after the long stall.
        send_nominal(8'h40, 0);
        check("post_done", 32'(done), 32'd1);
        check("post_core_rst", 32'(core_rst), 32'd0);
        check_queue_drained("post_writes");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
